// File: rtl/prog_loader_if.sv
// Load-stream handshake between a host and prog_loader.
// master drives iWord/iValid/iSel and sees oReady; slave is the reverse.
interface prog_loader_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] iWord;
  logic            iValid;
  logic            iSel;
  logic            oReady;

  modport master (
    output iWord, iValid, iSel,
    input  oReady
  );

  modport slave (
    input  iWord, iValid, iSel,
    output oReady
  );
endinterface

// File: rtl/prog_loader.sv
// Streams words into instruction/data memories, then starts the core.
// Ports: iClk, iRst (sync, active-low), iRestart, ld (load stream,
// slave), instruction/data write ports, oStart, oDone, oOvf, oChecksum.
// Optional macro PROG_LOADER_CHECKSUM_EN: XOR checksum of written words.
module prog_loader #(
  parameter int          XLEN       = 32,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] TERM_WORD  = 32'hDEADBEAF
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iRestart,
  prog_loader_if.slave                  ld,
  output logic [XLEN-1:0]               oInst2Write,
  output logic                          oInstWen,
  output logic [$clog2(IMEM_DEPTH)-1:0] oInstAddr,
  output logic [XLEN-1:0]               oData2Write,
  output logic                          oDataWen,
  output logic [$clog2(DMEM_DEPTH)-1:0] oDataAddr,
  output logic                          oStart,
  output logic                          oDone,
  output logic                          oOvf,
  output logic [XLEN-1:0]               oChecksum
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [XLEN-1:0] TERM = XLEN'(TERM_WORD);
  // Counters carry one extra bit so "full" is count == depth.
  localparam logic [IAW:0] IFULL = (IAW+1)'(IMEM_DEPTH);
  localparam logic [DAW:0] DFULL = (DAW+1)'(DMEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, ERR
  } state_t;

  state_t          state_q, state_d;
  logic [IAW:0]    icnt_q, icnt_d;
  logic [DAW:0]    dcnt_q, dcnt_d;
  logic            iwen_q, iwen_d;
  logic            dwen_q, dwen_d;
  logic [XLEN-1:0] iword_q, iword_d;
  logic [XLEN-1:0] dword_q, dword_d;
  logic [IAW-1:0]  iaddr_q, iaddr_d;
  logic [DAW-1:0]  daddr_q, daddr_d;
  logic            acc;

  // Restart drops any word offered in the same cycle.
  assign acc = ld.iValid & (state_q == LOAD) & ~iRestart;

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    iwen_d  = 1'b0;
    dwen_d  = 1'b0;
    iword_d = iword_q;
    dword_d = dword_q;
    iaddr_d = iaddr_q;
    daddr_d = daddr_q;
    unique case (state_q)
      IDLE:  state_d = LOAD;
      LOAD: begin
        if (acc) begin
          if (ld.iWord == TERM) begin
            state_d = START;
          end else if (!ld.iSel) begin
            if (icnt_q == IFULL) begin
              state_d = ERR;
            end else begin
              iwen_d  = 1'b1;
              iword_d = ld.iWord;
              iaddr_d = icnt_q[IAW-1:0];
              icnt_d  = icnt_q + 1'b1;
            end
          end else begin
            if (dcnt_q == DFULL) begin
              state_d = ERR;
            end else begin
              dwen_d  = 1'b1;
              dword_d = ld.iWord;
              daddr_d = dcnt_q[DAW-1:0];
              dcnt_d  = dcnt_q + 1'b1;
            end
          end
        end
      end
      START: state_d = RUN;
      RUN:   state_d = RUN;
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (iRestart) begin
      state_d = IDLE;
      icnt_d  = '0;
      dcnt_d  = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      iwen_q  <= 1'b0;
      dwen_q  <= 1'b0;
      iword_q <= '0;
      dword_q <= '0;
      iaddr_q <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      iwen_q  <= iwen_d;
      dwen_q  <= dwen_d;
      iword_q <= iword_d;
      dword_q <= dword_d;
      iaddr_q <= iaddr_d;
      daddr_q <= daddr_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] cks_q, cks_d;

  // Folded in on the same edge that raises the write enable.
  always_comb begin
    cks_d = cks_q;
    if (iwen_d) cks_d = cks_d ^ iword_d;
    if (dwen_d) cks_d = cks_d ^ dword_d;
    if (iRestart) cks_d = '0;
  end

  always_ff @(posedge iClk) begin
    if (!iRst) cks_q <= '0;
    else       cks_q <= cks_d;
  end

  assign oChecksum = cks_q;
`else
  assign oChecksum = '0;
`endif

  assign ld.oReady   = (state_q == LOAD);
  assign oStart      = (state_q == START);
  assign oDone       = (state_q == RUN);
  assign oOvf        = (state_q == ERR);
  assign oInstWen    = iwen_q;
  assign oInst2Write = iword_q;
  assign oInstAddr   = iaddr_q;
  assign oDataWen    = dwen_q;
  assign oData2Write = dword_q;
  assign oDataAddr   = daddr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a word-list loader model.
// Small memories (4 inst / 8 data) so overflow is exercised often.
module tb_prog_loader;
  localparam int XLEN = 32;
  localparam int ID = 4;
  localparam int DD = 8;
  localparam logic [31:0] TERM = 32'hDEADBEAF;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic iRestart = 1'b0;
  prog_loader_if #(.XLEN(XLEN)) ld();
  logic [XLEN-1:0] oInst2Write, oData2Write, oChecksum;
  logic oInstWen, oDataWen, oStart, oDone, oOvf;
  logic [1:0] oInstAddr;
  logic [2:0] oDataAddr;

  prog_loader #(
    .XLEN(XLEN), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iRestart(iRestart), .ld(ld),
    .oInst2Write(oInst2Write), .oInstWen(oInstWen),
    .oInstAddr(oInstAddr), .oData2Write(oData2Write),
    .oDataWen(oDataWen), .oDataAddr(oDataAddr),
    .oStart(oStart), .oDone(oDone), .oOvf(oOvf),
    .oChecksum(oChecksum)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int starts = 0;
  int both_hi = 0;

  typedef struct {
    bit          ch;
    int          addr;
    logic [31:0] w;
    int          c;
  } wr_t;

  wr_t obs[$];
  wr_t exq[$];
  logic [31:0] seq_w[$];
  bit          seq_s[$];

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (oInstWen)
      obs.push_back(wr_t'{ch:1'b0, addr:int'(oInstAddr),
                          w:oInst2Write, c:cyc});
    if (oDataWen)
      obs.push_back(wr_t'{ch:1'b1, addr:int'(oDataAddr),
                          w:oData2Write, c:cyc});
    if (oStart) starts++;
    if (oInstWen && oDataWen) both_hi++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic add(input bit s, input logic [31:0] w);
    seq_s.push_back(s);
    seq_w.push_back(w);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_iwen"}, oInstWen, 0);
    chk({tag, "_dwen"}, oDataWen, 0);
    chk({tag, "_start"}, oStart, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_ovf"}, oOvf, 0);
    chk({tag, "_rdy"}, ld.oReady, 0);
    chk({tag, "_cks"}, oChecksum, 0);
  endtask

  task automatic cmp_writes();
    chk("wr_count", obs.size(), exq.size());
    for (int k = 0; k < exq.size() && k < obs.size(); k++) begin
      chk("wr_ch", obs[k].ch, exq[k].ch);
      chk("wr_addr", obs[k].addr, exq[k].addr);
      chk("wr_word", obs[k].w, exq[k].w);
      chk("wr_lat", obs[k].c, exq[k].c);
    end
    obs.delete();
    exq.delete();
  endtask

  // mode 0: random iValid, mode 1: iValid toggles every cycle.
  // abort_n >= 0: pulse reset after that many accepted words.
  task automatic run_seq(input int mode, input int abort_n);
    int i, acc, tmo;
    int cnt[2];
    int dep[2];
    bit ended, term, ovf, tog, v, s;
    logic [31:0] w, x;
    i = 0; acc = 0; tmo = 0;
    cnt[0] = 0; cnt[1] = 0;
    dep[0] = ID; dep[1] = DD;
    ended = 0; term = 0; ovf = 0; tog = 1; x = '0;
    starts = 0; both_hi = 0;
    while (!ld.oReady && tmo < 20) begin
      @(negedge iClk);
      tmo++;
    end
    chk("ready_wait", ld.oReady, 1);
    while (i < seq_w.size() && !ended) begin
      v = (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
      tog = ~tog;
      w = seq_w[i];
      s = seq_s[i];
      ld.iValid = v;
      ld.iSel = s;
      ld.iWord = v ? w : $urandom;
      chk("ready_load", ld.oReady, 1);
      if (v) begin
        if (w == TERM) begin
          term = 1; ended = 1;
        end else if (cnt[s] == dep[s]) begin
          ovf = 1; ended = 1;
        end else begin
          exq.push_back(wr_t'{ch:s, addr:cnt[s], w:w, c:cyc + 1});
          cnt[s]++;
          x ^= w;
        end
        i++;
        acc++;
      end
      @(negedge iClk);
      if (abort_n >= 0 && acc == abort_n && !ended) begin
        iRst = 1'b0;
        ld.iValid = 1'b0;
        @(negedge iClk);
        chk_zero("rst_mid");
        chk("rst_iaddr", oInstAddr, 0);
        chk("rst_daddr", oDataAddr, 0);
        chk("rst_iword", oInst2Write, 0);
        chk("rst_dword", oData2Write, 0);
        iRst = 1'b1;
        cmp_writes();
        seq_w.delete();
        seq_s.delete();
        return;
      end
    end
    ld.iValid = 1'b0;
    repeat (3) @(negedge iClk);
    cmp_writes();
    chk("starts", starts, term);
    chk("done", oDone, term);
    chk("ovf", oOvf, ovf);
    chk("ready_end", ld.oReady, !(term || ovf));
    chk("no_dual_wen", both_hi, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("checksum", oChecksum, x);
`else
    chk("checksum", oChecksum, 0);
`endif
    seq_w.delete();
    seq_s.delete();
  endtask

  task automatic do_restart(input bit with_word);
    iRestart = 1'b1;
    if (with_word) begin
      ld.iValid = 1'b1;
      ld.iWord = $urandom;
      ld.iSel = 1'($urandom);
    end
    @(negedge iClk);
    iRestart = 1'b0;
    ld.iValid = 1'b0;
    chk_zero("restart");
    @(negedge iClk);
    chk("restart_drop", obs.size(), 0);
    obs.delete();
  endtask

  initial begin
    int n;
    ld.iValid = 1'b0;
    ld.iWord = '0;
    ld.iSel = 1'b0;
    repeat (3) @(negedge iClk);
    chk_zero("reset");
    chk("reset_iaddr", oInstAddr, 0);
    chk("reset_dword", oData2Write, 0);
    iRst = 1'b1;

    add(0, 32'h00000013); add(0, 32'h00100093); add(0, TERM);
    run_seq(0, -1);
    do_restart(0);

    add(0, 32'hA); add(1, 32'hB); add(0, 32'hC); add(1, TERM);
    run_seq(0, -1);
    do_restart(0);

    for (int k = 0; k < 5; k++) add(0, 32'h100 + k);
    run_seq(0, -1);
    do_restart(0);

    add(0, 32'h11); add(1, 32'h22); add(1, 32'h33); add(0, TERM);
    run_seq(1, -1);
    do_restart(0);

    for (int k = 0; k < 4; k++) add(0, 32'h5000 + k);
    run_seq(0, 2);
    add(0, 32'h77); add(1, 32'h88); add(0, TERM);
    run_seq(0, -1);
    do_restart(0);

    add(0, 32'hF0F0F0F0); add(1, 32'h0F0F0F0F); add(0, TERM);
    run_seq(0, -1);
    do_restart(0);

    repeat (2) @(negedge iClk);
    do_restart(1);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 14);
      for (int k = 0; k < n; k++)
        add(1'($urandom),
            ($urandom_range(0, 9) == 0) ? TERM : $urandom);
      run_seq(r % 2, -1);
      do_restart(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
